// File: rtl/wb2axip_fifo_reader.sv
// Drains a synchronous FIFO read port into a valid/ready stream through a 2-entry buffer.
// Optional packet framing (i_pkt_len / o_last) is enabled by defining WB2AXIP_FIFO_READER_LAST_EN.
module wb2axip_fifo_reader #(
  parameter int BW             = 8,
  parameter int OPT_RD_LATENCY = 0,
  parameter int LGPKT          = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  output logic             o_fifo_rd,
  input  logic             i_fifo_empty,
  input  logic [BW-1:0]    i_fifo_data,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [BW-1:0]    o_data
`ifdef WB2AXIP_FIFO_READER_LAST_EN
  ,
  input  logic [LGPKT-1:0] i_pkt_len,
  output logic             o_last
`endif
);

  if ((OPT_RD_LATENCY != 0 && OPT_RD_LATENCY != 1) || LGPKT < 1) begin : g_bad_param
    $error("wb2axip_fifo_reader: OPT_RD_LATENCY must be 0 or 1 and LGPKT at least 1");
  end

  logic [BW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    cnt;
  logic [1:0]    fill;
  logic          pending;
  logic          pop;
  logic          wr_en;

  // cnt reserves a slot for every word already requested, so a read is only issued
  // when the buffer is guaranteed to have room for it when it lands.
  assign pop       = o_valid && i_ready;
  assign o_fifo_rd = i_reset_n && !i_fifo_empty && ((cnt - {1'b0, pop}) < 2'd2);
  assign wr_en     = (OPT_RD_LATENCY == 0) ? o_fifo_rd : pending;
  assign o_valid   = (fill != 2'd0);
  assign o_data    = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt     <= 2'd0;
      fill    <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      pending <= 1'b0;
      mem[0]  <= '0;
      mem[1]  <= '0;
    end else begin
      cnt     <= cnt + {1'b0, o_fifo_rd} - {1'b0, pop};
      fill    <= fill + {1'b0, wr_en} - {1'b0, pop};
      pending <= (OPT_RD_LATENCY != 0) && o_fifo_rd;
      if (wr_en) begin
        mem[wr_ptr] <= i_fifo_data;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
    end
  end

`ifdef WB2AXIP_FIFO_READER_LAST_EN
  logic [LGPKT-1:0] beat_cnt;
  logic [LGPKT-1:0] last_idx;

  // A zero length is treated as a one-beat packet.
  assign last_idx = (i_pkt_len == '0) ? '0 : i_pkt_len - LGPKT'(1);
  assign o_last   = o_valid && (beat_cnt == last_idx);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      beat_cnt <= '0;
    end else if (pop) begin
      beat_cnt <= o_last ? '0 : beat_cnt + LGPKT'(1);
    end
  end
`endif

endmodule
